// File: rtl/carparking_pkg.sv
// Shared types and widths for the carparking password path.
package carparking_pkg;

    localparam int PW_DIGITS = 4;
    localparam int DIGIT_W   = 4;
    localparam int PW_W      = PW_DIGITS * DIGIT_W;
    localparam int CNT_W     = 3;

    typedef enum logic [1:0] {
        PW_IDLE    = 2'd0,
        PW_COLLECT = 2'd1,
        PW_READY   = 2'd2
    } pw_state_e;

endpackage

// File: rtl/key_debounce.sv
// Synchronizes a raw keypad strobe and emits exactly one key_acc pulse per
// physical press, with the digit captured on the accepting cycle.
module key_debounce
    import carparking_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               key_strobe,
    input  logic [DIGIT_W-1:0] key_code,
    output logic               key_acc,
    output logic [DIGIT_W-1:0] key_data
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYC);

    logic          sync1;
    logic          sync2;
    logic          armed;
    logic [CW-1:0] stable_cnt;
    logic          level_match;

    // While armed we look for a stable high; once fired, for a stable low.
    assign level_match = armed ? sync2 : ~sync2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            armed      <= 1'b1;
            stable_cnt <= '0;
            key_acc    <= 1'b0;
            key_data   <= '0;
        end else begin
            sync1   <= key_strobe;
            sync2   <= sync1;
            key_acc <= 1'b0;
            if (stable_cnt == CNT_MAX) begin
                stable_cnt <= '0;
                armed      <= ~armed;
                if (armed) begin
                    key_acc  <= 1'b1;
                    key_data <= key_code;
                end
            end else if (level_match) begin
                stable_cnt <= stable_cnt + 1'b1;
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/pw_entry_collector.sv
// Per-gate password entry: arms on the entry sensor, shifts four debounced hex
// digits in, and presents the 16-bit word on Enter or abandons it on timeout.
module pw_entry_collector
    import carparking_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 4,
    parameter int TIMEOUT_CYC  = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sensor_entry,
    input  logic               key_strobe,
    input  logic [DIGIT_W-1:0] key_code,
    input  logic               key_clear,
    input  logic               key_enter,
    output logic [PW_W-1:0]    password,
    output logic               pw_valid,
    output logic [CNT_W-1:0]   digit_count,
    output logic               busy,
    output logic               timeout,
    output pw_state_e          state
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(PW_DIGITS - 1);

    logic               key_acc;
    logic [DIGIT_W-1:0] key_data;
    logic               sensor_q;
    logic               sensor_rise;
    logic [PW_W-1:0]    shreg;
    logic [TW-1:0]      timer;

    key_debounce #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_key_debounce (
        .clk       (clk),
        .rst       (rst),
        .key_strobe(key_strobe),
        .key_code  (key_code),
        .key_acc   (key_acc),
        .key_data  (key_data)
    );

    assign sensor_rise = sensor_entry & ~sensor_q;

    // pw_valid is a one-cycle strobe qualifying password; the consumer has no
    // way to stall it, so it must sample on that exact cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= PW_IDLE;
            sensor_q    <= 1'b0;
            shreg       <= '0;
            timer       <= '0;
            password    <= '0;
            pw_valid    <= 1'b0;
            timeout     <= 1'b0;
            busy        <= 1'b0;
            digit_count <= '0;
        end else begin
            sensor_q <= sensor_entry;
            pw_valid <= 1'b0;
            timeout  <= 1'b0;
            case (state)
                PW_IDLE: begin
                    shreg       <= '0;
                    digit_count <= '0;
                    if (sensor_rise) begin
                        state <= PW_COLLECT;
                        busy  <= 1'b1;
                        timer <= TIMER_LOAD;
                    end
                end
                PW_COLLECT, PW_READY: begin
                    if (key_clear) begin
                        shreg       <= '0;
                        digit_count <= '0;
                        timer       <= TIMER_LOAD;
                        state       <= PW_COLLECT;
                    end else if (state == PW_READY && key_enter) begin
                        password    <= shreg;
                        pw_valid    <= 1'b1;
                        shreg       <= '0;
                        digit_count <= '0;
                        busy        <= 1'b0;
                        state       <= PW_IDLE;
                    end else if (state == PW_COLLECT && key_acc) begin
                        shreg       <= {shreg[PW_W-DIGIT_W-1:0], key_data};
                        digit_count <= digit_count + 1'b1;
                        timer       <= TIMER_LOAD;
                        if (digit_count == LAST_DIGIT) begin
                            state <= PW_READY;
                        end
                    end else if (timer == '0) begin
                        timeout     <= 1'b1;
                        shreg       <= '0;
                        digit_count <= '0;
                        busy        <= 1'b0;
                        state       <= PW_IDLE;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state <= PW_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pw_entry_collector.sv
// Directed plus randomized bench for pw_entry_collector against a digit-queue
// model of the entry rules.
module tb_pw_entry_collector;
    import carparking_pkg::*;

    localparam int DEB = 4;
    localparam int TMO = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sensor_entry = 1'b0;
    logic        key_strobe = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        key_clear = 1'b0;
    logic        key_enter = 1'b0;
    logic [15:0] password;
    logic        pw_valid;
    logic [2:0]  digit_count;
    logic        busy;
    logic        timeout;
    pw_state_e   state;

    pw_entry_collector #(
        .DEBOUNCE_CYC(DEB),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sensor_entry(sensor_entry),
        .key_strobe  (key_strobe),
        .key_code    (key_code),
        .key_clear   (key_clear),
        .key_enter   (key_enter),
        .password    (password),
        .pw_valid    (pw_valid),
        .digit_count (digit_count),
        .busy        (busy),
        .timeout     (timeout),
        .state       (state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // pulse monitor, sampled 2 time units after each rising edge
    int vld_cnt = 0;
    int to_cnt = 0;
    int cyc = 0;
    int last_acc_cyc = 0;
    int to_gap = -1;
    logic [2:0] prev_dc = 3'd0;

    always begin
        @(posedge clk);
        #2;
        cyc++;
        if (pw_valid === 1'b1) vld_cnt++;
        if (timeout === 1'b1) begin
            to_cnt++;
            to_gap = cyc - last_acc_cyc;
        end
        if (digit_count > prev_dc) last_acc_cyc = cyc;
        prev_dc = digit_count;
    end

    // reference model: collected digits, armed flag, last submitted word
    logic [3:0]  exp_q[$];
    bit          model_busy = 1'b0;
    logic [15:0] exp_pw = 16'h0000;

    function automatic logic [15:0] pack_pw();
        int v;
        v = 0;
        foreach (exp_q[i]) v = v * 16 + int'(exp_q[i]);
        return v[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks: each starts and ends just after a falling edge
    task automatic press(input logic [3:0] d, input int hold, input int extra, input bit clr);
        int exp_old;
        int exp_new;
        exp_old = exp_q.size();
        if (model_busy) begin
            if (clr) exp_q.delete();
            else if (exp_q.size() < 4) exp_q.push_back(d);
        end
        exp_new = exp_q.size();
        key_code   = d;
        key_strobe = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == hold) key_strobe = 1'b0;
            if (i == 7) begin
                check("count_before_accept", digit_count, exp_old);
                if (clr) key_clear = 1'b1;
            end
            if (i == 8) begin
                key_clear = 1'b0;
                check("count_after_accept", digit_count, exp_new);
            end
        end
        repeat (extra) @(negedge clk);
    endtask

    task automatic press_rand(input logic [3:0] d);
        int h;
        h = $urandom_range(4, 8);
        press(d, h, h + $urandom_range(0, 2), 1'b0);
    endtask

    task automatic arm();
        if (!model_busy) begin
            model_busy = 1'b1;
            exp_q.delete();
        end
        sensor_entry = 1'b1;
        @(negedge clk);
        sensor_entry = 1'b0;
        check("busy_after_arm", busy, model_busy);
        check("count_after_arm", digit_count, exp_q.size());
    endtask

    task automatic do_clear();
        key_clear = 1'b1;
        @(negedge clk);
        key_clear = 1'b0;
        if (model_busy) exp_q.delete();
        check("count_after_clear", digit_count, exp_q.size());
    endtask

    task automatic enter();
        int v0;
        bit fire;
        v0 = vld_cnt;
        fire = model_busy && (exp_q.size() == 4);
        key_enter = 1'b1;
        @(negedge clk);
        key_enter = 1'b0;
        if (fire) begin
            exp_pw = pack_pw();
            model_busy = 1'b0;
            exp_q.delete();
        end
        check("password", password, exp_pw);
        check("pw_valid", pw_valid, fire);
        check("busy_after_enter", busy, model_busy);
        check("count_after_enter", digit_count, exp_q.size());
        @(negedge clk);
        check("pw_valid_pulses", vld_cnt - v0, fire ? 1 : 0);
    endtask

    task automatic wait_timeout();
        int t0;
        int n;
        t0 = to_cnt;
        n = 0;
        while (to_cnt == t0 && n < 3 * TMO) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        model_busy = 1'b0;
        exp_q.delete();
        check("timeout_pulses", to_cnt - t0, 1);
        check("timeout_gap", to_gap, TMO);
        check("busy_after_timeout", busy, 1'b0);
        check("count_after_timeout", digit_count, 0);
        check("password_after_timeout", password, exp_pw);
    endtask

    initial begin
        int v0;
        int t0;
        int n;
        int clear_at;

        // reset values
        #1 rst = 1'b0;
        #1;
        check("rst_password", password, 16'h0000);
        check("rst_pw_valid", pw_valid, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_count", digit_count, 0);
        check("rst_state", state, PW_IDLE);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // key in IDLE is ignored
        press(4'h5, 6, 6, 1'b0);
        check("idle_state", state, PW_IDLE);

        // 1,2,3,4 enter
        arm();
        press_rand(4'h1);
        press_rand(4'h2);
        press_rand(4'h3);
        press_rand(4'h4);
        check("state_ready", state, PW_READY);
        enter();
        check("state_idle_after_enter", state, PW_IDLE);

        // 9,8 clear, 0,0,0,0 plus a fifth digit in READY
        arm();
        press_rand(4'h9);
        press_rand(4'h8);
        do_clear();
        press_rand(4'h0);
        press_rand(4'h0);
        press_rand(4'h0);
        press(4'h0, 4, 4, 1'b0);
        press(4'h7, 4, 4, 1'b0);
        enter();

        // glitch, bounce, clear-with-accept, enter at count 3, sensor re-edge
        arm();
        key_code = 4'h9;
        key_strobe = 1'b1;
        repeat (DEB - 1) @(negedge clk);
        key_strobe = 1'b0;
        repeat (6) @(negedge clk);
        check("glitch_count", digit_count, exp_q.size());
        do_clear();
        key_code = 4'h6;
        repeat (3) begin
            key_strobe = 1'b1;
            @(negedge clk);
            key_strobe = 1'b0;
            @(negedge clk);
        end
        key_strobe = 1'b1;
        repeat (8) @(negedge clk);
        key_strobe = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.push_back(4'h6);
        check("bounce_count", digit_count, exp_q.size());
        press_rand(4'hA);
        press(4'hB, 6, 8, 1'b1);
        press_rand(4'h3);
        press_rand(4'h1);
        press(4'h4, 4, 4, 1'b0);
        enter();
        arm();
        press_rand(4'h5);
        enter();

        // inactivity timeout after two digits
        arm();
        press_rand(4'hC);
        press_rand(4'hD);
        wait_timeout();

        // asynchronous reset mid-entry, then a fresh entry
        arm();
        press_rand(4'hE);
        press_rand(4'hF);
        v0 = vld_cnt;
        t0 = to_cnt;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        model_busy = 1'b0;
        exp_q.delete();
        exp_pw = 16'h0000;
        check("midrst_password", password, exp_pw);
        check("midrst_busy", busy, 1'b0);
        check("midrst_count", digit_count, 0);
        check("midrst_state", state, PW_IDLE);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_no_valid", vld_cnt - v0, 0);
        check("midrst_no_timeout", to_cnt - t0, 0);
        arm();
        for (int k = 0; k < 4; k++) press_rand(4'($urandom_range(0, 15)));
        enter();

        // randomized entries with optional clear
        for (int it = 0; it < 8; it++) begin
            arm();
            n = $urandom_range(2, 4);
            clear_at = $urandom_range(0, 8);
            for (int k = 0; k < n; k++) begin
                if (k == clear_at) do_clear();
                press_rand(4'($urandom_range(0, 15)));
            end
            enter();
            if (model_busy) wait_timeout();
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
